// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution stage.
//   - RV32I opcode constants for conditional branches, JAL and JALR
//   - funct3 encodings for the conditional branch comparisons
//   - BHT_INIT: reset value of every predictor counter (weakly not-taken)
//   - sat2_update: saturating 2-bit counter step toward taken / not-taken
package branch_pkg;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [2:0] F3_BEQ    = 3'b000;
    localparam logic [2:0] F3_BNE    = 3'b001;
    localparam logic [2:0] F3_RSVD0  = 3'b010;
    localparam logic [2:0] F3_RSVD1  = 3'b011;
    localparam logic [2:0] F3_BLT    = 3'b100;
    localparam logic [2:0] F3_BGE    = 3'b101;
    localparam logic [2:0] F3_BLTU   = 3'b110;
    localparam logic [2:0] F3_BGEU   = 3'b111;
    localparam logic [2:0] F3_JALR   = 3'b000;

    localparam logic [1:0] BHT_INIT  = 2'b01;

    // Move a 2-bit counter one step toward the observed outcome, sticking at
    // 2'b11 (strongly taken) and 2'b00 (strongly not-taken).
    function automatic logic [1:0] sat2_update(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        nxt = ctr;
        if (taken) begin
            if (ctr != 2'b11) nxt = ctr + 2'b01;
        end else begin
            if (ctr != 2'b00) nxt = ctr - 2'b01;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bht_2bit.sv
// Bimodal branch history table of 2-bit saturating counters.
// Ports:
//   iCLK, iRST     clock, synchronous active-high reset (all entries -> BHT_INIT)
//   lookup_pc      PC to predict for (combinational read)
//   lookup_taken   MSB of the addressed counter
//   upd_en         train the counter addressed by upd_pc this cycle
//   upd_pc         PC of the resolved conditional branch
//   upd_taken      resolved outcome
// A lookup and an update to the same entry in one cycle returns the value
// stored before the update, since the write lands on the clock edge.
module bht_2bit
    import branch_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int PC_LSB = 2,
    parameter int XLEN   = 32
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            lookup_taken,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [1:0]       ctr_q [DEPTH];
    logic [IDX_W-1:0] lookup_idx;
    logic [IDX_W-1:0] upd_idx;

    // Only the index slice of each PC addresses the table.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{lookup_pc, upd_pc};

    assign lookup_idx   = lookup_pc[PC_LSB +: IDX_W];
    assign upd_idx      = upd_pc[PC_LSB +: IDX_W];
    assign lookup_taken = ctr_q[lookup_idx][1];

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                ctr_q[i] <= BHT_INIT;
            end
        end else if (upd_en) begin
            ctr_q[upd_idx] <= sat2_update(ctr_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage: resolves BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR,
// computes target, link and redirect PC, flags mispredicts against the fetch
// prediction and trains a bimodal predictor.
// Ports:
//   iCLK, iRST                 clock, synchronous active-high reset
//   iVALID / oREADY            input handshake
//   iIR, iPC                   instruction word and its PC
//   iREG_OUT1, iREG_OUT2       rs1 / rs2 values
//   iPRED_TAKEN                prediction fetch used for this instruction
//   iLOOKUP_PC / oLOOKUP_TAKEN combinational predictor lookup for fetch
//   oVALID / iREADY            output handshake
//   oTAKEN, oTARGET, oLINK, oREDIRECT_PC, oMISPREDICT, oMISALIGN, oILLEGAL
//                              registered result of the accepted instruction
//   oBR_COUNT, oMISS_COUNT     saturating statistics counters
//
// Handshake: an input transfers on a clock edge where iVALID && oREADY; a
// result transfers on an edge where oVALID && iREADY. oREADY = !oVALID ||
// iREADY, so the single output register refills in the same cycle it drains
// and a stalled result holds every result output stable until taken.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int BHT_DEPTH = 64,
    parameter int PC_LSB    = 2
) (
    input  logic            iCLK,
    input  logic            iRST,
    input  logic            iVALID,
    output logic            oREADY,
    input  logic [31:0]     iIR,
    input  logic [XLEN-1:0] iPC,
    input  logic [XLEN-1:0] iREG_OUT1,
    input  logic [XLEN-1:0] iREG_OUT2,
    input  logic            iPRED_TAKEN,
    input  logic [XLEN-1:0] iLOOKUP_PC,
    output logic            oLOOKUP_TAKEN,
    output logic            oVALID,
    input  logic            iREADY,
    output logic            oTAKEN,
    output logic [XLEN-1:0] oTARGET,
    output logic [XLEN-1:0] oLINK,
    output logic [XLEN-1:0] oREDIRECT_PC,
    output logic            oMISPREDICT,
    output logic            oMISALIGN,
    output logic            oILLEGAL,
    output logic [31:0]     oBR_COUNT,
    output logic [31:0]     oMISS_COUNT
);

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            is_branch;
    logic            is_jal;
    logic            is_jalr;
    logic            cond_taken;
    logic            legal;
    logic            taken;
    logic            mispredict;
    logic            misalign;
    logic            accept;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] link;
    logic [XLEN-1:0] redirect;

    assign opcode = iIR[6:0];
    assign funct3 = iIR[14:12];

    assign imm_b = {{(XLEN-12){iIR[31]}}, iIR[7], iIR[30:25], iIR[11:8], 1'b0};
    assign imm_j = {{(XLEN-20){iIR[31]}}, iIR[19:12], iIR[20], iIR[30:21], 1'b0};
    assign imm_i = {{(XLEN-12){iIR[31]}}, iIR[31:20]};

    // is_branch / is_jalr are only set for legal encodings, so "legal" is
    // simply the OR of the three instruction classes.
    always_comb begin
        is_branch  = 1'b0;
        is_jal     = 1'b0;
        is_jalr    = 1'b0;
        cond_taken = 1'b0;

        case (opcode)
            OP_BRANCH: is_branch = (funct3 != F3_RSVD0) && (funct3 != F3_RSVD1);
            OP_JAL:    is_jal    = 1'b1;
            OP_JALR:   is_jalr   = (funct3 == F3_JALR);
            default:   ;
        endcase

        case (funct3)
            F3_BEQ:  cond_taken = (iREG_OUT1 == iREG_OUT2);
            F3_BNE:  cond_taken = (iREG_OUT1 != iREG_OUT2);
            F3_BLT:  cond_taken = ($signed(iREG_OUT1) <  $signed(iREG_OUT2));
            F3_BGE:  cond_taken = ($signed(iREG_OUT1) >= $signed(iREG_OUT2));
            F3_BLTU: cond_taken = (iREG_OUT1 <  iREG_OUT2);
            F3_BGEU: cond_taken = (iREG_OUT1 >= iREG_OUT2);
            default: cond_taken = 1'b0;
        endcase
    end

    assign legal      = is_branch | is_jal | is_jalr;
    assign taken      = is_branch ? cond_taken : (is_jal | is_jalr);
    assign target     = is_jalr ? ((iREG_OUT1 + imm_i) & ~XLEN'(1))
                                : (iPC + (is_jal ? imm_j : imm_b));
    assign link       = iPC + XLEN'(4);
    assign redirect   = taken ? target : link;
    assign mispredict = is_branch ? (cond_taken != iPRED_TAKEN)
                                  : ((is_jal | is_jalr) & ~iPRED_TAKEN);
    assign misalign   = taken & (target[1:0] != 2'b00);

    assign oREADY = !oVALID || iREADY;
    assign accept = iVALID && oREADY;

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oVALID       <= 1'b0;
            oTAKEN       <= 1'b0;
            oTARGET      <= '0;
            oLINK        <= '0;
            oREDIRECT_PC <= '0;
            oMISPREDICT  <= 1'b0;
            oMISALIGN    <= 1'b0;
            oILLEGAL     <= 1'b0;
            oBR_COUNT    <= '0;
            oMISS_COUNT  <= '0;
        end else begin
            if (accept) begin
                oVALID       <= 1'b1;
                oTAKEN       <= taken;
                oTARGET      <= target;
                oLINK        <= link;
                oREDIRECT_PC <= redirect;
                oMISPREDICT  <= mispredict;
                oMISALIGN    <= misalign;
                oILLEGAL     <= ~legal;
            end else if (iREADY) begin
                oVALID <= 1'b0;
            end

            // Statistics count at accept time, not when the result drains.
            if (accept && legal && (oBR_COUNT != 32'hFFFF_FFFF)) begin
                oBR_COUNT <= oBR_COUNT + 32'd1;
            end
            if (accept && mispredict && (oMISS_COUNT != 32'hFFFF_FFFF)) begin
                oMISS_COUNT <= oMISS_COUNT + 32'd1;
            end
        end
    end

    // Only legal conditional branches train; jumps are always taken anyway.
    bht_2bit #(
        .DEPTH  (BHT_DEPTH),
        .PC_LSB (PC_LSB),
        .XLEN   (XLEN)
    ) u_bht (
        .iCLK         (iCLK),
        .iRST         (iRST),
        .lookup_pc    (iLOOKUP_PC),
        .lookup_taken (oLOOKUP_TAKEN),
        .upd_en       (accept & is_branch),
        .upd_pc       (iPC),
        .upd_taken    (cond_taken)
    );

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int XLEN  = 32;
    localparam int DEPTH = 64;
    localparam int RES_W = 4 + 5 * 32;

    // ---------------- clock / reset / DUT ----------------
    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iVALID;
    logic        oREADY;
    logic [31:0] iIR;
    logic [31:0] iPC;
    logic [31:0] iREG_OUT1;
    logic [31:0] iREG_OUT2;
    logic        iPRED_TAKEN;
    logic [31:0] iLOOKUP_PC;
    logic        oLOOKUP_TAKEN;
    logic        oVALID;
    logic        iREADY;
    logic        oTAKEN;
    logic [31:0] oTARGET;
    logic [31:0] oLINK;
    logic [31:0] oREDIRECT_PC;
    logic        oMISPREDICT;
    logic        oMISALIGN;
    logic        oILLEGAL;
    logic [31:0] oBR_COUNT;
    logic [31:0] oMISS_COUNT;

    always #5 iCLK = ~iCLK;

    branch_resolve_unit #(.XLEN(XLEN), .BHT_DEPTH(DEPTH), .PC_LSB(2)) dut (
        .iCLK(iCLK), .iRST(iRST), .iVALID(iVALID), .oREADY(oREADY),
        .iIR(iIR), .iPC(iPC), .iREG_OUT1(iREG_OUT1), .iREG_OUT2(iREG_OUT2),
        .iPRED_TAKEN(iPRED_TAKEN), .iLOOKUP_PC(iLOOKUP_PC),
        .oLOOKUP_TAKEN(oLOOKUP_TAKEN), .oVALID(oVALID), .iREADY(iREADY),
        .oTAKEN(oTAKEN), .oTARGET(oTARGET), .oLINK(oLINK),
        .oREDIRECT_PC(oREDIRECT_PC), .oMISPREDICT(oMISPREDICT),
        .oMISALIGN(oMISALIGN), .oILLEGAL(oILLEGAL),
        .oBR_COUNT(oBR_COUNT), .oMISS_COUNT(oMISS_COUNT)
    );

    // ---------------- scoreboard state and reference model ----------------
    int unsigned      checks = 0;
    int unsigned      errors = 0;
    logic [RES_W-1:0] exp_q[$];
    int unsigned      m_bht[DEPTH];
    int unsigned      m_br;
    int unsigned      m_miss;
    bit               m_ovalid;

    task automatic check(input string name, input logic [RES_W-1:0] act, input logic [RES_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Target is only meaningful for legal instructions, so it is zeroed out of
    // the comparison record when the illegal flag is set.
    function automatic logic [RES_W-1:0] pack_res(input bit taken, input bit mis, input bit misal,
                                                  input bit ill, input logic [31:0] tgt,
                                                  input logic [31:0] link, input logic [31:0] redir,
                                                  input logic [31:0] br, input logic [31:0] miss);
        return {taken, mis, misal, ill, (ill ? 32'd0 : tgt), link, redir, br, miss};
    endfunction

    function automatic int imm_b(input int unsigned ir);
        int v;
        v = (((ir >> 31) & 1) << 12) | (((ir >> 7) & 1) << 11) |
            (((ir >> 25) & 63) << 5) | (((ir >> 8) & 15) << 1);
        if (v >= 4096) v = v - 8192;
        return v;
    endfunction

    function automatic int imm_j(input int unsigned ir);
        int v;
        v = (((ir >> 31) & 1) << 20) | (((ir >> 12) & 255) << 12) |
            (((ir >> 20) & 1) << 11) | (((ir >> 21) & 1023) << 1);
        if (v >= 1048576) v = v - 2097152;
        return v;
    endfunction

    function automatic int imm_i(input int unsigned ir);
        int v;
        v = (ir >> 20) & 4095;
        if (v >= 2048) v = v - 4096;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_bht[i] = 1;
        m_br     = 0;
        m_miss   = 0;
        m_ovalid = 0;
        exp_q.delete();
    endtask

    task automatic model_accept(input logic [31:0] ir, input logic [31:0] pc,
                                input logic [31:0] r1, input logic [31:0] r2, input bit pred);
        int unsigned op, f3, tgt, link, redir;
        bit legal, is_br, taken, mis, misal;
        int idx;
        op    = ir & 32'h7f;
        f3    = (ir >> 12) & 7;
        link  = pc + 4;
        legal = 0; is_br = 0; taken = 0; tgt = 0;
        if (op == 32'h63 && f3 != 2 && f3 != 3) begin
            legal = 1; is_br = 1;
            tgt = pc + imm_b(ir);
            case (f3)
                0: taken = (r1 == r2);
                1: taken = (r1 != r2);
                4: taken = ($signed(r1) <  $signed(r2));
                5: taken = ($signed(r1) >= $signed(r2));
                6: taken = (r1 <  r2);
                default: taken = (r1 >= r2);
            endcase
        end else if (op == 32'h6f) begin
            legal = 1; taken = 1;
            tgt = pc + imm_j(ir);
        end else if (op == 32'h67 && f3 == 0) begin
            legal = 1; taken = 1;
            tgt = (r1 + imm_i(ir)) & 32'hFFFF_FFFE;
        end
        mis   = legal && (taken != pred);
        misal = taken && ((tgt % 4) != 0);
        redir = taken ? tgt : link;
        if (legal && m_br != 32'hFFFF_FFFF) m_br++;
        if (mis && m_miss != 32'hFFFF_FFFF) m_miss++;
        if (is_br) begin
            idx = (pc / 4) % DEPTH;
            if (taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else       m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        exp_q.push_back(pack_res(taken, mis, misal, !legal, tgt, link, redir, m_br, m_miss));
    endtask

    task automatic check_lookup();
        check("lookup", oLOOKUP_TAKEN, (m_bht[(iLOOKUP_PC >> 2) % DEPTH] >= 2));
    endtask

    // ---------------- driver tasks ----------------
    task automatic send(input logic [31:0] ir, input logic [31:0] pc, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] lpc, input bit pred,
                        input int hold, input bit rnd_rdy);
        bit acc;
        bit exp_rdy;
        int k;
        acc = 0;
        k   = 0;
        while (!acc) begin
            @(negedge iCLK);
            iVALID = 1'b1; iIR = ir; iPC = pc; iREG_OUT1 = r1; iREG_OUT2 = r2;
            iPRED_TAKEN = pred; iLOOKUP_PC = lpc;
            if (k < hold)     iREADY = 1'b0;
            else if (rnd_rdy) iREADY = ($urandom_range(0, 3) != 0);
            else              iREADY = 1'b1;
            #1;
            check_lookup();
            exp_rdy = !m_ovalid || iREADY;
            check("ready", oREADY, exp_rdy);
            if (exp_rdy) begin
                model_accept(ir, pc, r1, r2, pred);
                acc = 1;
                m_ovalid = 1;
            end
            k++;
            if (!acc && k > 40) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout actual=stalled required=accept within 40 cycles");
                acc = 1;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            iVALID = 1'b0; iREADY = 1'b1;
            iLOOKUP_PC = $urandom_range(0, 255) * 4;
            #1;
            check_lookup();
            check("ready_idle", oREADY, !m_ovalid || iREADY);
            m_ovalid = 0;
        end
    endtask

    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic rand_send();
        logic [31:0] w, pc, r1, r2, lpc;
        int sel;
        w   = $urandom();
        sel = $urandom_range(0, 9);
        if (sel <= 5) begin
            w[6:0] = 7'h63;
        end else if (sel == 6) begin
            w[6:0] = 7'h6f;
        end else if (sel == 7) begin
            w[6:0] = 7'h67;
            if ($urandom_range(0, 3) != 0) w[14:12] = 3'b000;
        end else if (sel == 8) begin
            w[6:0] = 7'h13;
        end
        pc = $urandom_range(0, 255) * 4;
        if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFF0 + $urandom_range(0, 3) * 4;
        r1 = ($urandom_range(0, 2) == 0) ? $urandom() : $urandom_range(0, 4);
        r2 = ($urandom_range(0, 2) == 0) ? $urandom() : $urandom_range(0, 4);
        if ($urandom_range(0, 7) == 0) r1 = 32'hFFFF_FFFF;
        lpc = ($urandom_range(0, 1) == 0) ? pc : $urandom_range(0, 255) * 4;
        send(w, pc, r1, r2, lpc, $urandom_range(0, 1), 0, 1);
    endtask

    // ---------------- monitor ----------------
    logic [RES_W-1:0] cur_res;
    logic [RES_W-1:0] prev_res;
    bit               prev_stall = 0;

    always @(negedge iCLK) begin
        #2;
        cur_res = pack_res(oTAKEN, oMISPREDICT, oMISALIGN, oILLEGAL, oTARGET, oLINK,
                           oREDIRECT_PC, oBR_COUNT, oMISS_COUNT);
        if (iRST) begin
            prev_stall = 0;
        end else begin
            if (prev_stall && oVALID) check("stall_hold", cur_res, prev_res);
            if (oVALID && iREADY) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%0h required=no result", cur_res);
                end else begin
                    check("result", cur_res, exp_q.pop_front());
                end
            end
            prev_stall = oVALID && !iREADY;
            prev_res   = cur_res;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        iRST = 1'b1; iVALID = 1'b0; iREADY = 1'b1; iIR = '0; iPC = '0;
        iREG_OUT1 = '0; iREG_OUT2 = '0; iPRED_TAKEN = 1'b0; iLOOKUP_PC = 32'h100;
        model_reset();
        repeat (2) @(negedge iCLK);
        #1;
        check("reset_valid", oVALID, 1'b0);
        check("reset_ready", oREADY, 1'b1);
        check("reset_outputs",
              pack_res(oTAKEN, oMISPREDICT, oMISALIGN, oILLEGAL, oTARGET, oLINK, oREDIRECT_PC,
                       oBR_COUNT, oMISS_COUNT), '0);
        check_lookup();
        @(negedge iCLK);
        iRST = 1'b0;

        // BEQ +16 at 0x100, equal operands, predicted not-taken
        send(enc_b(13'd16, 3'b000), 32'h100, 5, 5, 32'h100, 0, 0, 0);
        // backward BEQ, not taken
        send(enc_b(13'h1FF0, 3'b000), 32'h104, 5, 6, 32'h104, 1, 0, 0);
        // signed vs unsigned compares
        send(enc_b(13'd8, 3'b100), 32'h300, 32'hFFFF_FFFF, 1, 32'h300, 0, 0, 0);
        send(enc_b(13'd8, 3'b110), 32'h304, 32'hFFFF_FFFF, 1, 32'h304, 0, 0, 0);
        send(enc_b(13'd8, 3'b101), 32'h308, 32'hFFFF_FFFF, 1, 32'h308, 1, 0, 0);
        send(enc_b(13'd8, 3'b111), 32'h30C, 32'hFFFF_FFFF, 1, 32'h30C, 1, 0, 0);
        // JALR rs1=0x1003 imm=+4, misaligned target
        send({12'd4, 5'd1, 3'b000, 5'd1, 7'h67}, 32'h400, 32'h1003, 0, 32'h400, 1, 0, 0);
        // train 0x200 taken three times, then not taken once
        repeat (3) send(enc_b(13'd8, 3'b001), 32'h200, 1, 2, 32'h200, 1, 0, 0);
        send(enc_b(13'd8, 3'b001), 32'h200, 2, 2, 32'h200, 1, 0, 0);
        idle(1);
        // stall: second instruction waits three cycles, then back-to-back drain
        send(enc_b(13'd12, 3'b000), 32'h500, 7, 7, 32'h500, 1, 0, 0);
        send({20'h00010, 5'd1, 7'h6f}, 32'h504, 0, 0, 32'h504, 0, 3, 0);
        send(enc_b(13'd4, 3'b001), 32'h508, 1, 1, 32'h508, 0, 0, 0);
        // illegal encodings
        send(32'h0000_0013, 32'h600, 1, 2, 32'h600, 1, 0, 0);
        send(enc_b(13'd8, 3'b010), 32'h604, 1, 2, 32'h604, 1, 0, 0);
        send({12'd4, 5'd1, 3'b001, 5'd1, 7'h67}, 32'h608, 32'h10, 0, 32'h608, 1, 0, 0);
        idle(2);

        repeat (200) rand_send();

        // reset while a result is valid
        send(enc_b(13'd8, 3'b000), 32'h200, 3, 3, 32'h200, 1, 0, 0);
        @(negedge iCLK);
        iRST = 1'b1; iVALID = 1'b0; iREADY = 1'b0;
        #1;
        check("valid_before_reset", oVALID, 1'b1);
        @(posedge iCLK);
        #1;
        check("valid_after_reset", oVALID, 1'b0);
        check("br_count_after_reset", oBR_COUNT, 32'd0);
        model_reset();
        @(negedge iCLK);
        iRST = 1'b0;
        idle(4);

        repeat (200) rand_send();

        idle(4);
        check("queue_drained", exp_q.size(), 0);
        check("br_count_final", oBR_COUNT, m_br);
        check("miss_count_final", oMISS_COUNT, m_miss);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
